// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, with
// valid/ready handshakes on the operand and result sides.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   n_q, n_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     trial;
    logic               fits;

    // Partial remainder shifted left with the next dividend bit appended.
    assign trial = {r_q, n_q[WIDTH-1]};
    assign fits  = (trial >= {1'b0, dvs_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            dvs_q   <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            dvs_q   <= dvs_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        dvs_d   = dvs_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvs_d   = divisor;
                    dbz_d   = (divisor == '0);
                    state_d = BUSY;
                    if (divisor == '0) begin
                        // Result is final now; the single BUSY pass keeps the
                        // divide-by-zero latency at one cycle after acceptance.
                        n_d   = '1;
                        r_d   = dividend;
                        cnt_d = '0;
                    end else begin
                        n_d   = dividend;
                        r_d   = '0;
                        cnt_d = CNT_W'(WIDTH - 1);
                    end
                end
            end
            BUSY: begin
                if (dbz_q) begin
                    state_d = DONE;
                end else begin
                    r_d = fits ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
                    n_d = {n_q[WIDTH-2:0], fits};
                    if (cnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = n_q;
    assign remainder   = r_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed vectors on an 8-bit instance,
// randomized operands with output stalls on 8-bit and 16-bit instances.
module tb_seq_divider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, dbz8;
    logic [7:0]  dividend8, divisor8, q8, r8;
    logic        in_valid16, in_ready16, out_valid16, out_ready16, dbz16;
    logic [15:0] dividend16, divisor16, q16, r16;

    logic dir_ready8, rnd_mode, rnd8, rnd16;
    assign out_ready8  = rnd_mode ? rnd8 : dir_ready8;
    assign out_ready16 = rnd16;

    seq_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .dividend(dividend8), .divisor(divisor8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
    );

    seq_divider #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .dividend(dividend16), .divisor(divisor16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .quotient(q16), .remainder(r16), .div_by_zero(dbz16)
    );

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
    } exp_t;

    exp_t sb8[$];
    exp_t sb16[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Random output stalls, changed just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        rnd8  = ($urandom_range(0, 3) != 0);
        rnd16 = ($urandom_range(0, 2) != 0);
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid8 === 1'b1 && out_ready8 === 1'b1) begin
            if (sb8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result8: got q=%0d r=%0d, expected no result", q8, r8);
            end else begin
                exp_t e;
                e = sb8.pop_front();
                check("quotient8", 32'(q8), 32'(e.q));
                check("remainder8", 32'(r8), 32'(e.r));
                check("div_by_zero8", 32'(dbz8), 32'(e.dbz));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid16 === 1'b1 && out_ready16 === 1'b1) begin
            if (sb16.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result16: got q=%0d r=%0d, expected no result", q16, r16);
            end else begin
                exp_t e;
                e = sb16.pop_front();
                check("quotient16", 32'(q16), 32'(e.q));
                check("remainder16", 32'(r16), 32'(e.r));
                check("div_by_zero16", 32'(dbz16), 32'(e.dbz));
            end
        end
    end

    task automatic op8(input logic [7:0] n, input logic [7:0] d, input logic [7:0] eq,
                       input logic [7:0] er, input logic edbz, input int elat, input string nm);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (in_ready8 !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        if (in_ready8 !== 1'b1) check({nm, "_in_ready_timeout"}, 32'(in_ready8), 32'd1);
        e.q = 16'(eq); e.r = 16'(er); e.dbz = edbz;
        sb8.push_back(e);
        in_valid8 = 1'b1; dividend8 = n; divisor8 = d;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        dividend8 = 8'($urandom);
        divisor8  = 8'($urandom);
        cyc = 0;
        while (out_valid8 !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        if (elat > 0) check({nm, "_latency"}, cyc, elat);
        else if (out_valid8 !== 1'b1) check({nm, "_out_valid_timeout"}, 32'(out_valid8), 32'd1);
    endtask

    task automatic op16(input logic [15:0] n, input logic [15:0] d);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (in_ready16 !== 1'b1 && cyc < 300) begin
            @(posedge clk); #1; cyc++;
        end
        if (in_ready16 !== 1'b1) check("rnd16_in_ready_timeout", 32'(in_ready16), 32'd1);
        e.q   = (d == 0) ? 16'hFFFF : n / d;
        e.r   = (d == 0) ? n : n % d;
        e.dbz = (d == 0);
        sb16.push_back(e);
        in_valid16 = 1'b1; dividend16 = n; divisor16 = d;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        dividend16 = 16'($urandom);
        divisor16  = 16'($urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int         cnt;
        logic [7:0]  n, d;
        logic [15:0] n16, d16;
        rst_n = 1'b0;
        in_valid8 = 1'b0; dividend8 = '0; divisor8 = '0;
        in_valid16 = 1'b0; dividend16 = '0; divisor16 = '0;
        dir_ready8 = 1'b1; rnd_mode = 1'b0; rnd8 = 1'b1; rnd16 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready8), 32'd1);
        check("reset_out_valid", 32'(out_valid8), 32'd0);
        check("reset_quotient", 32'(q8), 32'd0);
        check("reset_remainder", 32'(r8), 32'd0);
        check("reset_div_by_zero", 32'(dbz8), 32'd0);
        rst_n = 1'b1;

        // Abort mid-operation with an asynchronous reset.
        @(posedge clk); #1;
        in_valid8 = 1'b1; dividend8 = 8'd200; divisor8 = 8'd7;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("midbusy_in_ready_before", 32'(in_ready8), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midbusy_reset_in_ready", 32'(in_ready8), 32'd1);
        check("midbusy_reset_out_valid", 32'(out_valid8), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid8 === 1'b1) cnt++;
        end
        check("midbusy_no_result", cnt, 0);

        op8(8'd200, 8'd7,   8'd28,  8'd4,  1'b0, 8, "basic");
        op8(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 8, "n255_d1");
        op8(8'd0,   8'd9,   8'd0,   8'd0,  1'b0, 8, "n0_d9");
        op8(8'd5,   8'd200, 8'd0,   8'd5,  1'b0, 8, "n5_d200");
        op8(8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 8, "n255_d255");
        op8(8'd77,  8'd0,   8'hFF,  8'd77, 1'b1, 1, "div0");
        op8(8'd10,  8'd3,   8'd3,   8'd1,  1'b0, 8, "after_div0");

        // Backpressure: result must hold while out_ready stays low.
        cnt = 0;
        while (in_ready8 !== 1'b1 && cnt < 50) begin
            @(posedge clk); #1; cnt++;
        end
        dir_ready8 = 1'b0;
        op8(8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 8, "bp");
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_hold_out_valid", 32'(out_valid8), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready8), 32'd0);
            check("bp_hold_quotient", 32'(q8), 32'd33);
            check("bp_hold_remainder", 32'(r8), 32'd1);
        end
        dir_ready8 = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", 32'(out_valid8), 32'd0);
        check("bp_release_in_ready", 32'(in_ready8), 32'd1);

        rnd_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            n = 8'($urandom);
            d = ($urandom_range(0, 15) == 0) ? 8'd0 :
                ($urandom_range(0, 1) == 0) ? 8'($urandom_range(1, 15)) : 8'($urandom_range(1, 255));
            op8(n, d, (d == 0) ? 8'hFF : n / d, (d == 0) ? n : n % d, (d == 0), 0, "rnd8");
        end

        for (int i = 0; i < 300; i++) begin
            n16 = 16'($urandom);
            d16 = ($urandom_range(0, 15) == 0) ? 16'd0 :
                  ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
            op16(n16, d16);
        end

        cnt = 0;
        while ((sb8.size() != 0 || sb16.size() != 0) && cnt < 1000) begin
            @(posedge clk); #1; cnt++;
        end
        check("drain8", sb8.size(), 0);
        check("drain16", sb16.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
